clk_monitor: RTL and testbench
==============================

CLK_MONITOR -- requirements
Module: clk_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of all measurement counters.
REQ-002 SHALL have parameter EXP_HIGH, default 3, expected high time in clk cycles.
REQ-003 SHALL have parameter EXP_LOW, default 7, expected low time in clk cycles.
REQ-004 SHALL have parameter TOL, default 1, allowed absolute deviation in cycles.
REQ-005 SHALL have parameter TIMEOUT, default 64, cycles without a clk_in edge before stuck.
REQ-006 SHALL have port clk  input  1  free-running sampling clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port mon_en  input  1  enables measurement.
REQ-009 SHALL have port clk_in  input  1  asynchronous clock under test, from the clock generator.
REQ-010 SHALL have port meas_ready  input  1  consumer accepts the measurement.
REQ-011 SHALL have port meas_valid  output  1  measurement available.
REQ-012 SHALL have port high_cnt  output  CNT_W  measured high time.
REQ-013 SHALL have port period_cnt  output  CNT_W  measured period (high+low).
REQ-014 SHALL have port freq_err  output  1  period outside tolerance.
REQ-015 SHALL have port duty_err  output  1  high time outside tolerance.
REQ-016 SHALL have port stuck  output  1  sticky no-edge timeout flag.

Function
REQ-017 SHALL pass clk_in through a 2-flop synchronizer plus one edge-detect flop, so an edge is detected 3 clk cycles after it is sampled.
REQ-018 SHALL implement the states IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW and REPORT.
REQ-019 SHALL go IDLE->WAIT_RISE when mon_en=1, WAIT_RISE->MEAS_HIGH on a rise, MEAS_HIGH->MEAS_LOW on a fall, and MEAS_LOW->REPORT on the next rise.
REQ-020 SHALL count clk cycles from rise detect to fall detect as high time, and from fall detect to rise detect as low time; each counter saturates at 2^CNT_W-1.
REQ-021 SHALL, on entering REPORT, register high_cnt, period_cnt = high+low (saturating), freq_err = |period-(EXP_HIGH+EXP_LOW)|>TOL and duty_err.
REQ-022 SHALL drive meas_valid=1 in REPORT and keep all outputs stable until meas_valid&&meas_ready, then go to WAIT_RISE; clk_in edges are ignored while in REPORT.
REQ-023 SHALL, on a handshake and a clk_in rise in the same cycle, discard the rise and wait for the next one.
REQ-024 SHALL maintain an idle counter cleared on every detected edge; in WAIT_RISE/MEAS_HIGH/MEAS_LOW, reaching TIMEOUT sets stuck and returns the FSM to WAIT_RISE.
REQ-025 SHALL clear stuck only on reset or mon_en=0.
REQ-026 SHALL, when mon_en=0 in any state, go to IDLE on the next cycle, clear counters, and drop meas_valid, aborting any pending report.

Reset
REQ-027 SHALL, with rst=0 at a clk edge, set state=IDLE, synchronizer flops=0, all counters=0, meas_valid=0, high_cnt=0, period_cnt=0, freq_err=0, duty_err=0 and stuck=0.
REQ-028 SHALL let reset override mon_en and meas_ready; after release, measurement restarts from WAIT_RISE at the first rise.

Configuration
REQ-029 SHALL, with CLK_MON_DUTY_CHECK_EN defined, compute duty_err = |high-EXP_HIGH|>TOL.
REQ-030 SHALL, without CLK_MON_DUTY_CHECK_EN, tie duty_err to 0 and omit its comparator; high_cnt is still reported.

Structure
REQ-031 SHALL place the FSM state enum and the saturating-add width constant in the shared package clk_mon_pkg.
REQ-032 SHALL instantiate the synchronizer as the sub-module sync_2ff.

Verification
REQ-033 SHALL cover: clk_in high 3 / low 7 clk cycles -> meas_valid with high_cnt=3, period_cnt=10, freq_err=0, duty_err=0.
REQ-034 SHALL cover: clk_in 5/5 with the macro defined -> high_cnt=5, period_cnt=10, duty_err=1, freq_err=0; with the macro undefined -> duty_err=0.
REQ-035 SHALL cover: clk_in 2/4 -> period_cnt=6, freq_err=1.
REQ-036 SHALL cover: clk_in held low after mon_en=1 -> stuck=1 after 64 cycles, meas_valid=0; then mon_en=0 -> stuck=0.
REQ-037 SHALL cover: meas_ready=0 for 20 cycles in REPORT -> meas_valid and data held constant; meas_ready=1 -> one handshake, then return to WAIT_RISE.
REQ-038 SHALL cover: rst=0 asserted during MEAS_LOW -> all outputs 0 on the next cycle; after release, the first report is a full 3/7 measurement.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock monitor: FSM state encoding and
// the carry width used by saturating adds.
package clk_mon_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT_RISE = 3'd1;
  localparam state_t ST_MEAS_HIGH = 3'd2;
  localparam state_t ST_MEAS_LOW  = 3'd3;
  localparam state_t ST_REPORT    = 3'd4;

  // Extra MSBs carried through a saturating add to detect overflow.
  localparam int SAT_GUARD_W = 1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clk_monitor.sv
// Measures high time and period of an asynchronous clock, flags frequency,
// duty-cycle (when CLK_MON_DUTY_CHECK_EN is defined) and stuck-clock faults.
module clk_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int EXP_HIGH = 3,
  parameter int EXP_LOW  = 7,
  parameter int TOL      = 1,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_en,
  input  logic             clk_in,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             freq_err,
  output logic             duty_err,
  output logic             stuck
);

  localparam int               IDLE_W   = $clog2(TIMEOUT + 1);
  localparam int               SUM_W    = CNT_W + SAT_GUARD_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] EXP_PER  = CNT_W'(EXP_HIGH + EXP_LOW);
  localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(TOL);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Edge detection on the synchronized clock
  logic clk_in_s, prev_q;
  logic rise, fall, any_edge;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (clk_in),
    .q_o (clk_in_s)
  );

  always_ff @(posedge clk) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= clk_in_s;
  end

  assign rise     = clk_in_s & ~prev_q;
  assign fall     = ~clk_in_s & prev_q;
  assign any_edge = rise | fall;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hi_q, hi_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               stuck_q, stuck_d;
  logic               load_rpt;
  logic               timeout_hit;

  logic [SUM_W-1:0]   sum_w;
  logic [CNT_W-1:0]   period_sat;
  logic               freq_bad;

  // cnt_q holds the low time when the closing rise arrives
  assign sum_w      = SUM_W'(hi_q) + SUM_W'(cnt_q);
  assign period_sat = (sum_w[SUM_W-1:CNT_W] != '0) ? CNT_MAX : sum_w[CNT_W-1:0];
  assign freq_bad   = abs_diff(period_sat, EXP_PER) > TOL_C;

  assign timeout_hit = !any_edge && (idle_q == IDLE_LAST) &&
                       (state_q == ST_WAIT_RISE || state_q == ST_MEAS_HIGH ||
                        state_q == ST_MEAS_LOW);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    idle_d   = idle_q;
    stuck_d  = stuck_q;
    load_rpt = 1'b0;
    if (!mon_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = '0;
      idle_d  = '0;
      stuck_d = 1'b0;
    end else begin
      idle_d = any_edge ? '0 : idle_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_RISE;
          idle_d  = '0;
        end
        ST_WAIT_RISE: begin
          if (rise) begin
            state_d = ST_MEAS_HIGH;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_MEAS_HIGH: begin
          if (fall) begin
            state_d = ST_MEAS_LOW;
            hi_d    = cnt_q;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        ST_MEAS_LOW: begin
          if (rise) begin
            state_d  = ST_REPORT;
            load_rpt = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        ST_REPORT: begin
          // Edges are ignored here; a rise coinciding with the handshake is lost.
          idle_d = '0;
          if (meas_ready) begin
            state_d = ST_WAIT_RISE;
            hi_d    = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (timeout_hit) begin
        stuck_d = 1'b1;
        state_d = ST_WAIT_RISE;
        cnt_d   = '0;
        hi_d    = '0;
        idle_d  = '0;
      end
    end
  end

  logic [CNT_W-1:0] high_cnt_q, period_q;
  logic             ferr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      idle_q     <= '0;
      stuck_q    <= 1'b0;
      high_cnt_q <= '0;
      period_q   <= '0;
      ferr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      idle_q  <= idle_d;
      stuck_q <= stuck_d;
      if (load_rpt) begin
        high_cnt_q <= hi_q;
        period_q   <= period_sat;
        ferr_q     <= freq_bad;
      end
    end
  end

`ifdef CLK_MON_DUTY_CHECK_EN
  logic derr_q;
  logic duty_bad;

  localparam logic [CNT_W-1:0] EXP_HI_C = CNT_W'(EXP_HIGH);
  assign duty_bad = abs_diff(hi_q, EXP_HI_C) > TOL_C;

  always_ff @(posedge clk) begin
    if (!rst)          derr_q <= 1'b0;
    else if (load_rpt) derr_q <= duty_bad;
  end

  assign duty_err = derr_q;
`else
  assign duty_err = 1'b0;
`endif

  assign meas_valid = (state_q == ST_REPORT);
  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_q;
  assign freq_err   = ferr_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Scoreboard bench for clk_monitor: directed clk_in waveforms, expected
// reports queued at stimulus time and checked by a monitor on each handshake.
module tb_clk_monitor;

  logic        clk = 1'b0;
  logic        rst, mon_en, clk_in, meas_ready;
  logic        meas_valid, freq_err, duty_err, stuck;
  logic [15:0] high_cnt, period_cnt;

  always #5 clk = ~clk;

  clk_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .mon_en     (mon_en),
    .clk_in     (clk_in),
    .meas_ready (meas_ready),
    .meas_valid (meas_valid),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .freq_err   (freq_err),
    .duty_err   (duty_err),
    .stuck      (stuck)
  );

  typedef struct {
    logic [31:0] h;
    logic [31:0] p;
    logic [31:0] f;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every accepted report against the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (meas_valid === 1'b1 && meas_ready === 1'b1) begin
        exp_t e;
        if (sb.size() == 0) begin
          check("spurious_report", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("high_cnt",   32'(high_cnt),   e.h);
          check("period_cnt", 32'(period_cnt), e.p);
          check("freq_err",   32'(freq_err),   e.f);
          check("duty_err",   32'(duty_err),   e.d);
        end
      end
    end
  end

  task automatic push_exp(input int h, input int p, input bit f, input bit d);
    exp_t e;
    e.h = 32'(h);
    e.p = 32'(p);
    e.f = 32'(f);
`ifdef CLK_MON_DUTY_CHECK_EN
    e.d = 32'(d);
`else
    e.d = 32'd0;
`endif
    sb.push_back(e);
  endtask

  // High h, low l, then a one-cycle closing rise and a quiet gap
  task automatic drive_wave(input int h, input int l);
    clk_in = 1'b1; repeat (h) tick();
    clk_in = 1'b0; repeat (l) tick();
    clk_in = 1'b1; tick();
    clk_in = 1'b0;
  endtask

  task automatic run_vec(input int h, input int l, input int p, input bit f, input bit d);
    push_exp(h, p, f, d);
    drive_wave(h, l);
    repeat (16) tick();
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int w;
    int bad;
    rst = 1'b0; mon_en = 1'b0; clk_in = 1'b0; meas_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid",  32'(meas_valid), 32'd0);
    check("rst_high",   32'(high_cnt),   32'd0);
    check("rst_period", 32'(period_cnt), 32'd0);
    check("rst_ferr",   32'(freq_err),   32'd0);
    check("rst_derr",   32'(duty_err),   32'd0);
    check("rst_stuck",  32'(stuck),      32'd0);
    rst = 1'b1; tick();
    mon_en = 1'b1; repeat (3) tick();

    // h, l, period, freq_err, duty_err (when duty check compiled in)
    run_vec(3, 7, 10, 1'b0, 1'b0);
    run_vec(5, 5, 10, 1'b0, 1'b1);
    run_vec(2, 4,  6, 1'b1, 1'b0);
    run_vec(4, 7, 11, 1'b0, 1'b0);
    run_vec(3, 9, 12, 1'b1, 1'b0);

    // Back-pressure: report must hold steady while the consumer stalls
    meas_ready = 1'b0;
    push_exp(3, 10, 1'b0, 1'b0);
    drive_wave(3, 7);
    w = 0;
    while (meas_valid !== 1'b1 && w < 20) begin tick(); w++; end
    check("hold_valid_seen", 32'(meas_valid), 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!(meas_valid === 1'b1 && high_cnt === 16'd3 && period_cnt === 16'd10 &&
            freq_err === 1'b0 && duty_err === 1'b0)) bad++;
      tick();
    end
    check("hold_stable", 32'(bad), 32'd0);
    meas_ready = 1'b1;
    tick();
    check("one_handshake", 32'(meas_valid), 32'd0);
    check("hold_drain", 32'(sb.size()), 32'd0);
    repeat (4) tick();
    run_vec(3, 7, 10, 1'b0, 1'b0);

    // Stuck clock: restart monitoring with clk_in parked low
    mon_en = 1'b0; repeat (2) tick();
    mon_en = 1'b1;
    repeat (40) tick();
    check("stuck_early", 32'(stuck), 32'd0);
    repeat (40) tick();
    check("stuck_set",   32'(stuck),      32'd1);
    check("stuck_valid", 32'(meas_valid), 32'd0);
    mon_en = 1'b0; repeat (2) tick();
    check("stuck_clear", 32'(stuck), 32'd0);

    // Reset in the middle of the low phase
    mon_en = 1'b1; repeat (3) tick();
    clk_in = 1'b1; repeat (3) tick();
    clk_in = 1'b0; repeat (3) tick();
    rst = 1'b0; tick();
    check("mid_rst_valid",  32'(meas_valid), 32'd0);
    check("mid_rst_high",   32'(high_cnt),   32'd0);
    check("mid_rst_period", 32'(period_cnt), 32'd0);
    check("mid_rst_ferr",   32'(freq_err),   32'd0);
    check("mid_rst_derr",   32'(duty_err),   32'd0);
    check("mid_rst_stuck",  32'(stuck),      32'd0);
    tick();
    rst = 1'b1; repeat (5) tick();
    run_vec(3, 7, 10, 1'b0, 1'b0);

    check("final_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
